// File: rtl/cic_decimator.sv
// CIC decimation filter: ORDER integrators at the input rate, ORDER combs at the
// decimated rate, then a saturating gain-compensation shift down to width_out.
module cic_decimator #(
   parameter int ORDER     = 3,
   parameter int M_MAX     = 250,
   parameter int width_in  = 2,
   parameter int width_out = 16,
   localparam int W    = width_in + ORDER*$clog2(M_MAX),
   localparam int RW   = $clog2(M_MAX+1),
   localparam int SMAX = ORDER*$clog2(M_MAX),
   localparam int SW   = $clog2(SMAX+1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [RW-1:0]               ratio,
   input  logic [SW-1:0]               shift,
   input  logic                        in_valid,
   input  logic signed [width_in-1:0]  in,
   output logic                        out_valid,
   output logic signed [width_out-1:0] out,
   output logic                        sat
);

   localparam int VW = W + SMAX;

   function automatic logic [RW-1:0] clamp_ratio(input logic [RW-1:0] r);
      logic [RW-1:0] res;
      res = r;
      if (r <= RW'(1))
         res = RW'(1);
      else if (r > RW'(M_MAX))
         res = RW'(M_MAX);
      return res;
   endfunction

   function automatic logic [SW-1:0] clamp_shift(input logic [SW-1:0] s);
      logic [SW-1:0] res;
      res = s;
      if (s > SW'(SMAX))
         res = SW'(SMAX);
      return res;
   endfunction

   // Returns {sat_flag, out_sample}; the shift is clamped upstream so VW bits never overflow.
   function automatic logic [width_out:0] scale_sat(input logic signed [W-1:0] x,
                                                    input logic [SW-1:0] sh);
      logic signed [VW-1:0] v;
      logic signed [W-1:0]  c;
      logic                 f;
      v = {{SMAX{x[W-1]}}, x};
      v = v <<< sh;
      if (v[VW-1:W-1] == '0 || v[VW-1:W-1] == '1) begin
         c = v[W-1:0];
         f = 1'b0;
      end else if (v[VW-1]) begin
         c = {1'b1, {(W-1){1'b0}}};
         f = 1'b1;
      end else begin
         c = {1'b0, {(W-1){1'b1}}};
         f = 1'b1;
      end
      return {f, width_out'(c >>> (W - width_out))};
   endfunction

   logic                load_first;
   logic [RW-1:0]       cnt;
   logic [RW-1:0]       r_q;
   logic [SW-1:0]       s_q;
   logic [RW-1:0]       r_eff;
   logic [SW-1:0]       s_eff;
   logic                dec_evt;

   logic signed [W-1:0] in_ext;
   logic signed [W-1:0] acc;
   logic signed [W-1:0] integ_p0 [ORDER];
   logic signed [W-1:0] integ_nx [ORDER];
   logic                vld_p0;
   logic [SW-1:0]       sh_p0;

   logic signed [W-1:0] comb_p1 [ORDER];
   logic signed [W-1:0] prev_p1 [ORDER];
   logic                vld_p1  [ORDER];
   logic [SW-1:0]       sh_p1   [ORDER];
   logic signed [W-1:0] cin     [ORDER];
   logic                cvld    [ORDER];
   logic [SW-1:0]       csh     [ORDER];

   // Right after reset the ports are used directly so the very first frame already
   // runs at the requested ratio (ratio 1 must fire on the first accepted sample).
   always_comb begin
      r_eff   = load_first ? clamp_ratio(ratio) : r_q;
      s_eff   = load_first ? clamp_shift(shift) : s_q;
      dec_evt = in_valid && (cnt >= r_eff - RW'(1));
      in_ext  = {{(W-width_in){in[width_in-1]}}, in};
      acc     = in_ext;
      for (int k = 0; k < ORDER; k++) begin
         acc         = integ_p0[k] + acc;
         integ_nx[k] = acc;
      end
   end

   // Stage p0: integrators, sample counter and per-frame ratio/shift latch
   always_ff @(posedge clk) begin
      if (reset) begin
         load_first <= 1'b1;
         cnt        <= '0;
         r_q        <= RW'(M_MAX);
         s_q        <= '0;
         vld_p0     <= 1'b0;
         sh_p0      <= '0;
         for (int k = 0; k < ORDER; k++)
            integ_p0[k] <= '0;
      end else begin
         load_first <= 1'b0;
         vld_p0     <= dec_evt;
         if (load_first) begin
            r_q <= r_eff;
            s_q <= s_eff;
         end
         if (in_valid) begin
            for (int k = 0; k < ORDER; k++)
               integ_p0[k] <= integ_nx[k];
            if (dec_evt) begin
               cnt   <= '0;
               r_q   <= clamp_ratio(ratio);
               s_q   <= clamp_shift(shift);
               sh_p0 <= s_eff;
            end else begin
               cnt <= cnt + RW'(1);
            end
         end
      end
   end

   always_comb begin
      cin[0]  = integ_p0[ORDER-1];
      cvld[0] = vld_p0;
      csh[0]  = sh_p0;
      for (int k = 1; k < ORDER; k++) begin
         cin[k]  = comb_p1[k-1];
         cvld[k] = vld_p1[k-1];
         csh[k]  = sh_p1[k-1];
      end
   end

   // Stage p1: comb chain, one differencing stage per cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < ORDER; k++) begin
            vld_p1[k]  <= 1'b0;
            comb_p1[k] <= '0;
            prev_p1[k] <= '0;
            sh_p1[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < ORDER; k++) begin
            vld_p1[k] <= cvld[k];
            if (cvld[k]) begin
               comb_p1[k] <= cin[k] - prev_p1[k];
               prev_p1[k] <= cin[k];
               sh_p1[k]   <= csh[k];
            end
         end
      end
   end

   // Stage p2: gain shift, saturation and truncation to the output width
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out       <= '0;
         sat       <= 1'b0;
      end else begin
         out_valid <= vld_p1[ORDER-1];
         if (vld_p1[ORDER-1])
            {sat, out} <= scale_sat(comb_p1[ORDER-1], sh_p1[ORDER-1]);
      end
   end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: steady-state gains, saturation, latency,
// gapped input, mid-frame ratio change, mid-operation reset and ratio clamping.
module tb_cic_decimator;

   localparam int ORDER = 3;
   localparam int M_MAX = 250;
   localparam int WIN   = 2;
   localparam int WOUT  = 16;
   localparam int RW    = $clog2(M_MAX+1);
   localparam int SW    = $clog2(ORDER*$clog2(M_MAX)+1);

   logic                   clk = 1'b0;
   logic                   reset;
   logic [RW-1:0]          ratio;
   logic [SW-1:0]          shift;
   logic                   in_valid;
   logic signed [WIN-1:0]  in_s;
   logic                   out_valid;
   logic signed [WOUT-1:0] out_s;
   logic                   sat;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_out = 0;
   int prev_out = 0;
   int rst_cyc  = 0;

   always #5 clk = ~clk;

   cic_decimator #(
      .ORDER(ORDER), .M_MAX(M_MAX), .width_in(WIN), .width_out(WOUT)
   ) dut (
      .clk(clk), .reset(reset), .ratio(ratio), .shift(shift),
      .in_valid(in_valid), .in(in_s),
      .out_valid(out_valid), .out(out_s), .sat(sat)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      tick();
      reset   = 1'b0;
      rst_cyc = cyc;
   endtask

   task automatic next_out(input int budget);
      int n;
      n        = 0;
      prev_out = last_out;
      do begin
         tick();
         n++;
      end while (out_valid !== 1'b1 && n < budget);
      last_out = cyc;
   endtask

   // First pulse is timed from reset, later ones from the previous pulse.
   task automatic steady(input string tag, input int n, input int r, input int first_chk,
                         input int exp_out, input int exp_sat);
      for (int k = 1; k <= n; k++) begin
         next_out(r + 10);
         check({tag, "_seen"}, 32'(out_valid), 1);
         if (k == 1)
            check({tag, "_lat"}, last_out - rst_cyc, r + 4);
         else
            check({tag, "_spacing"}, last_out - prev_out, r);
         if (k >= first_chk) begin
            check({tag, "_out"}, 32'(out_s), exp_out);
            check({tag, "_sat"}, 32'(sat), exp_sat);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int xs[12] = '{1, -2, 0, -1, 1, 1, -2, -1, 0, 1, -2, -1};
      int acc_n;
      int ev;
      int pulses;

      reset    = 1'b1;
      ratio    = 8'd250;
      shift    = 5'd0;
      in_valid = 1'b0;
      in_s     = 2'b01;
      tick();

      // +1 at ratio 250, no shift: 250^3 >> 10 = 15258
      do_reset();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out", 32'(out_s), 0);
      check("rst_sat", 32'(sat), 0);
      in_valid = 1'b1;
      steady("pos250", 6, 250, 4, 15258, 0);
      tick();
      check("hold_valid", 32'(out_valid), 0);
      check("hold_out", 32'(out_s), 15258);

      // -1: floor(-15625000 / 1024) = -15259
      in_s = 2'b11;
      do_reset();
      in_valid = 1'b1;
      steady("neg250", 6, 250, 4, -15259, 0);

      // ratio 10, shift 14: 1000 << 14 >> 10 = 16000, then a mid-frame ratio change
      ratio = 8'd10;
      shift = 5'd14;
      in_s  = 2'b01;
      do_reset();
      in_valid = 1'b1;
      steady("r10", 6, 10, 4, 16000, 0);
      ratio = 8'd250;
      next_out(300);
      check("rchg_old_seen", 32'(out_valid), 1);
      check("rchg_old_spacing", last_out - prev_out, 10);
      next_out(300);
      check("rchg_new_seen", 32'(out_valid), 1);
      check("rchg_new_spacing", last_out - prev_out, 250);

      // shift 2 overflows the accumulator range in both directions
      shift = 5'd2;
      do_reset();
      in_valid = 1'b1;
      steady("satpos", 5, 250, 4, 32767, 1);
      in_s = 2'b11;
      do_reset();
      in_valid = 1'b1;
      steady("satneg", 5, 250, 4, -32768, 1);

      // ratio 4 with in_valid toggling: pulse 4 edges after every 4th accepted sample
      ratio  = 8'd4;
      shift  = 5'd0;
      in_s   = 2'b01;
      do_reset();
      acc_n  = 0;
      ev     = -100;
      pulses = 0;
      for (int i = 0; i < 64; i++) begin
         in_valid = (i % 2 == 0);
         tick();
         if (in_valid) begin
            acc_n++;
            if (acc_n % 4 == 0) ev = cyc;
         end
         if (out_valid === 1'b1) begin
            pulses++;
            check("gap_lat", cyc - ev, 4);
         end
      end
      check("gap_pulses", pulses, 7);

      // reset two edges after a decimation event discards that result
      ratio = 8'd250;
      do_reset();
      in_valid = 1'b1;
      repeat (251) tick();
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      rst_cyc = cyc;
      check("midrst_valid", 32'(out_valid), 0);
      check("midrst_out", 32'(out_s), 0);
      pulses = 0;
      repeat (10) begin
        tick();
        if (out_valid !== 1'b0) pulses++;
      end
      check("midrst_quiet", pulses, 0);
      next_out(300);
      check("midrst_seen", 32'(out_valid), 1);
      check("midrst_lat", last_out - rst_cyc, 254);

      // ratio 0 acts as 1: the filter is an identity delayed by 4, scaled by 2^24 >> 10
      ratio = 8'd0;
      shift = 5'd24;
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_s = (i < 12) ? 2'(xs[i]) : 2'b00;
         tick();
         if (i == 3)
            check("r1_pre_valid", 32'(out_valid), 0);
         if (i >= 4) begin
            check("r1_valid", 32'(out_valid), 1);
            check("r1_out", 32'(out_s), xs[i-4] * 16384);
            check("r1_sat", 32'(sat), 0);
         end
      end

      // shift 31 clamps to 24
      ratio = 8'd1;
      shift = 5'd31;
      in_s  = 2'b01;
      do_reset();
      in_valid = 1'b1;
      repeat (6) tick();
      check("shclamp_valid", 32'(out_valid), 1);
      check("shclamp_out", 32'(out_s), 16384);
      check("shclamp_sat", 32'(sat), 0);

      // ratio 255 clamps to 250
      ratio = 8'd255;
      shift = 5'd0;
      do_reset();
      in_valid = 1'b1;
      steady("r255", 3, 250, 99, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
